cordic_atan_sched: RTL

- Shares one iterative CORDIC vectoring (atan) core among NREQ requesters using round-robin arbitration.
- Performs quadrant pre-rotation so the core only ever sees x >= 0.
- Sequences the core through a start/done handshake, applies the ±pi correction to the result and returns theta tagged with the requester ID.
- Sits between the per-channel angle consumers and the single shared core instance.

---
 rtl/cordic_atan_sched.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/cordic_atan_sched.sv
// Round-robin scheduler sharing one CORDIC vectoring core among NREQ requesters,
// with quadrant pre-rotation and +/-pi correction. CORDIC_SCHED_TIMEOUT_EN adds a WAIT watchdog.
module cordic_atan_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_x,
  input  logic [16*NREQ-1:0]   req_y,
  output logic                 core_start,
  output logic [15:0]          core_x,
  output logic [15:0]          core_y,
  input  logic                 core_valid,
  input  logic [31:0]          core_theta,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_theta,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic signed [31:0] PI_Q16 = 32'sd205887;

  if (NREQ < 2 || NREQ > 8 || IDW < $clog2(NREQ) || TIMEOUT < 2) begin : g_param_check
    $error("cordic_atan_sched: illegal NREQ/IDW/TIMEOUT combination");
  end

  logic [1:0]            state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        id_q, id_d;
  logic signed [15:0]    cx_q, cx_d;
  logic signed [15:0]    cy_q, cy_d;
  logic                  flip_q, flip_d;
  logic                  sgn_q, sgn_d;
  logic signed [31:0]    theta_q, theta_d;

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
`endif

  // Arbiter: first valid requester at or after the pointer, wrapping.
  logic                  gnt_found;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW-1:0]        scan_idx;
  logic signed [15:0]    sel_x, sel_y;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = IDW'((32'(ptr_q) + i) % 32'(NREQ));
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
        sel_x     = req_x[16*scan_idx +: 16];
        sel_y     = req_y[16*scan_idx +: 16];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Saturating negation: -(-32768) clamps to +32767.
  logic signed [15:0]    neg_x, neg_y;
  logic signed [31:0]    core_th;

  always_comb begin
    neg_x   = (sel_x == 16'sh8000) ? 16'sh7fff : -sel_x;
    neg_y   = (sel_y == 16'sh8000) ? 16'sh7fff : -sel_y;
    core_th = core_theta;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    flip_d  = flip_q;
    sgn_d   = sgn_q;
    theta_d = theta_q;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          id_d   = gnt_idx;
          ptr_d  = IDW'((32'(gnt_idx) + 32'd1) % 32'(NREQ));
          flip_d = sel_x[15];
          sgn_d  = !sel_y[15];
          cx_d   = sel_x[15] ? neg_x : sel_x;
          cy_d   = sel_x[15] ? neg_y : sel_y;
`ifdef CORDIC_SCHED_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          // Positive real axis (and the origin) answers 0 without the core.
          if (sel_y == 16'sd0 && !sel_x[15]) begin
            theta_d = '0;
            state_d = RESP;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
`ifdef CORDIC_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (core_valid) begin
          if (!flip_q) begin
            theta_d = core_th;
          end else if (sgn_q) begin
            theta_d = core_th + PI_Q16;
          end else begin
            theta_d = core_th - PI_Q16;
          end
          state_d = RESP;
        end
`ifdef CORDIC_SCHED_TIMEOUT_EN
        else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          theta_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      flip_q  <= 1'b0;
      sgn_q   <= 1'b0;
      theta_q <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      flip_q  <= flip_d;
      sgn_q   <= sgn_d;
      theta_q <= theta_d;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign core_start = (state_q == LAUNCH);
  assign core_x     = cx_q;
  assign core_y     = cy_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_theta  = theta_q;
  assign busy       = (state_q != IDLE);
`ifdef CORDIC_SCHED_TIMEOUT_EN
  assign rsp_err    = err_q;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
